// File: rtl/cv32e40x_pkg.sv
// ---------------------------------------------------------------------------
// Module   : cv32e40x_pkg
// Brief    : Shared types for the OBI responder slice.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package cv32e40x_pkg;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } obi_resp_entry_t;

endpackage

`default_nettype wire

// File: rtl/cv32e40x_resp_fifo.sv
// ---------------------------------------------------------------------------
// Module   : cv32e40x_resp_fifo
// Brief    : Synchronous response FIFO without fall-through.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40x_resp_fifo
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH   = 2,
  parameter type         ENTRY_T = obi_resp_entry_t,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  ENTRY_T           push_data,
  input  logic             pop,
  output ENTRY_T           pop_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned      PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] c_last  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  ENTRY_T           r_mem [DEPTH];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W-1:0] r_rptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  assign empty    = (r_count == '0);
  assign full     = (r_count == c_depth);
  assign count    = r_count;
  assign w_push   = push && !full;
  assign w_pop    = pop && !empty;
  assign pop_data = r_mem[r_rptr];

  // Storage carries no reset; only valid slots are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_one;
        2'b01:   r_count <= r_count - c_one;
        default: r_count <= r_count;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n) !(pop && empty));

endmodule

`default_nettype wire

// File: rtl/cv32e40x_obi_responder.sv
// ---------------------------------------------------------------------------
// Module   : cv32e40x_obi_responder
// Brief    : OBI slave fronting a 1-cycle word SRAM with in-order responses.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module cv32e40x_obi_responder
  import cv32e40x_pkg::*;
#(
  parameter int unsigned DEPTH          = 2,
  parameter logic [31:0] REGION_START   = 32'h0000_0000,
  parameter logic [31:0] REGION_END     = 32'h0000_3FFF,
  parameter int unsigned MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      obi_req_i,
  output logic                      obi_gnt_o,
  input  logic [31:0]               obi_addr_i,
  input  logic                      obi_we_i,
  input  logic [3:0]                obi_be_i,
  input  logic [31:0]               obi_wdata_i,
  output logic                      obi_rvalid_o,
  output logic [31:0]               obi_rdata_o,
  output logic                      obi_err_o,
  input  logic                      resp_stall_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr_o,
  output logic [3:0]                mem_be_o,
  output logic [31:0]               mem_wdata_o,
  input  logic [31:0]               mem_rdata_i
);

  localparam int unsigned      CNT_W   = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  logic [CNT_W-1:0] r_outstanding;
  logic             r_s1_valid;
  logic             r_s1_err;
  logic             r_s1_we;

  logic             w_accept;
  logic             w_in_range;
  obi_resp_entry_t  w_s1_entry;
  obi_resp_entry_t  w_head;
  logic             w_fifo_empty;
  logic             w_fifo_full;
  logic [CNT_W-1:0] w_fifo_count;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;

  assign obi_gnt_o  = obi_req_i && (r_outstanding < c_depth);
  assign w_accept   = obi_req_i && obi_gnt_o;
  assign w_in_range = (obi_addr_i >= REGION_START) && (obi_addr_i <= REGION_END);

  // Region start is word aligned, so subtracting on the word field alone is exact.
  assign mem_req_o   = w_accept && w_in_range;
  assign mem_we_o    = mem_req_o && obi_we_i;
  assign mem_addr_o  = obi_addr_i[MEM_ADDR_WIDTH+1:2] - REGION_START[MEM_ADDR_WIDTH+1:2];
  assign mem_be_o    = obi_be_i;
  assign mem_wdata_o = obi_wdata_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_err   <= 1'b0;
      r_s1_we    <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      r_s1_err   <= w_accept && !w_in_range;
      r_s1_we    <= w_accept && obi_we_i;
    end
  end

  always_comb begin
    w_s1_entry       = '0;
    w_s1_entry.err   = r_s1_valid && r_s1_err;
    if (r_s1_valid && !r_s1_err && !r_s1_we) begin
      w_s1_entry.rdata = mem_rdata_i;
    end
  end

  // Older entries in the FIFO always drain before the stage-1 entry.
  assign w_bypass = r_s1_valid && w_fifo_empty && !resp_stall_i;
  assign w_push   = r_s1_valid && !w_bypass;
  assign w_pop    = !w_fifo_empty && !resp_stall_i;

  cv32e40x_resp_fifo #(
    .DEPTH   (DEPTH),
    .ENTRY_T (obi_resp_entry_t),
    .CNT_W   (CNT_W)
  ) u_resp_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_data (w_s1_entry),
    .pop       (w_pop),
    .pop_data  (w_head),
    .empty     (w_fifo_empty),
    .full      (w_fifo_full),
    .count     (w_fifo_count)
  );

  always_comb begin
    obi_rvalid_o = 1'b0;
    obi_rdata_o  = '0;
    obi_err_o    = 1'b0;
    if (w_pop) begin
      obi_rvalid_o = 1'b1;
      obi_rdata_o  = w_head.rdata;
      obi_err_o    = w_head.err;
    end else if (w_bypass) begin
      obi_rvalid_o = 1'b1;
      obi_rdata_o  = w_s1_entry.rdata;
      obi_err_o    = w_s1_entry.err;
    end
  end

  // Credits return one cycle after the response, never combinationally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outstanding <= '0;
    end else begin
      case ({w_accept, obi_rvalid_o})
        2'b10:   r_outstanding <= r_outstanding + c_one;
        2'b01:   r_outstanding <= r_outstanding - c_one;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  a_rvalid_needs_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
    obi_rvalid_o |-> (r_outstanding != '0));
  a_gnt_needs_req: assert property (@(posedge clk) disable iff (!rst_n)
    obi_gnt_o |-> obi_req_i);
  a_mem_req_in_range: assert property (@(posedge clk) disable iff (!rst_n)
    mem_req_o |-> w_in_range);
  a_count_consistent: assert property (@(posedge clk) disable iff (!rst_n)
    r_outstanding == (w_fifo_count + CNT_W'(r_s1_valid)));
  a_fifo_not_full_on_push: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> !w_fifo_full);

endmodule

`default_nettype wire

// File: tb/tb_cv32e40x_obi_responder.sv
// ---------------------------------------------------------------------------
// Module   : tb_cv32e40x_obi_responder
// Brief    : Directed self-checking bench with a behavioural word SRAM.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_cv32e40x_obi_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        obi_req_i;
  logic        obi_gnt_o;
  logic [31:0] obi_addr_i;
  logic        obi_we_i;
  logic [3:0]  obi_be_i;
  logic [31:0] obi_wdata_i;
  logic        obi_rvalid_o;
  logic [31:0] obi_rdata_o;
  logic        obi_err_o;
  logic        resp_stall_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [11:0] mem_addr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata_i;

  logic [31:0] sram [0:4095];
  int          n_checks = 0;
  int          n_errors = 0;

  cv32e40x_obi_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .obi_req_i    (obi_req_i),
    .obi_gnt_o    (obi_gnt_o),
    .obi_addr_i   (obi_addr_i),
    .obi_we_i     (obi_we_i),
    .obi_be_i     (obi_be_i),
    .obi_wdata_i  (obi_wdata_i),
    .obi_rvalid_o (obi_rvalid_o),
    .obi_rdata_o  (obi_rdata_o),
    .obi_err_o    (obi_err_o),
    .resp_stall_i (resp_stall_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_be_o     (mem_be_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_req_o) begin
      if (mem_we_o) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be_o[b]) sram[mem_addr_o][8*b +: 8] <= mem_wdata_o[8*b +: 8];
        end
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic cyc(input logic req, input logic we, input logic [31:0] addr,
                     input logic [3:0] be, input logic [31:0] wdata, input logic stall);
    @(negedge clk);
    obi_req_i    = req;
    obi_we_i     = we;
    obi_addr_i   = addr;
    obi_be_i     = be;
    obi_wdata_i  = wdata;
    resp_stall_i = stall;
    #1;
  endtask

  task automatic check_rsp(input string tag, input logic v, input logic [31:0] d, input logic e);
    check({tag, "_rvalid"}, 32'(obi_rvalid_o), 32'(v));
    check({tag, "_rdata"},  obi_rdata_o, d);
    check({tag, "_err"},    32'(obi_err_o), 32'(e));
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) sram[i] = 32'h0;
    sram[4]      = 32'hDEAD_BEEF;
    sram[5]      = 32'h5566_7788;
    sram[8]      = 32'hAAAA_AAAA;
    mem_rdata_i  = 32'h0;
    rst_n        = 1'b0;
    obi_req_i    = 1'b0;
    obi_we_i     = 1'b0;
    obi_addr_i   = 32'h0;
    obi_be_i     = 4'hF;
    obi_wdata_i  = 32'h0;
    resp_stall_i = 1'b0;

    // Reset state
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("reset", 0, 32'h0, 0);
    check("reset_mem_req", 32'(mem_req_o), 0);
    check("reset_gnt", 32'(obi_gnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Load word 4
    cyc(1, 0, 32'h10, 4'hF, 0, 0);
    check("ld_gnt", 32'(obi_gnt_o), 1);
    check("ld_mem_req", 32'(mem_req_o), 1);
    check("ld_mem_we", 32'(mem_we_o), 0);
    check("ld_mem_addr", 32'(mem_addr_o), 4);
    check_rsp("ld_t0", 0, 32'h0, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("ld_t1", 1, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("ld_t2", 0, 32'h0, 0);

    // Partial store then read back
    cyc(1, 1, 32'h20, 4'b0011, 32'h1234_5678, 0);
    check("st_gnt", 32'(obi_gnt_o), 1);
    check("st_mem_we", 32'(mem_we_o), 1);
    check("st_mem_addr", 32'(mem_addr_o), 8);
    check("st_mem_be", 32'(mem_be_o), 32'h3);
    check("st_mem_wdata", mem_wdata_o, 32'h1234_5678);
    cyc(1, 0, 32'h20, 4'hF, 0, 0);
    check_rsp("st_rsp", 1, 32'h0, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("st_readback", 1, 32'hAAAA_5678, 0);

    // Out of range
    cyc(1, 0, 32'h0000_4000, 4'hF, 0, 0);
    check("oor_gnt", 32'(obi_gnt_o), 1);
    check("oor_mem_req", 32'(mem_req_o), 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("oor_rsp", 1, 32'h0, 1);

    // Stall fills the window, release drains in order
    cyc(1, 0, 32'h10, 4'hF, 0, 1);
    check("stl_gnt0", 32'(obi_gnt_o), 1);
    cyc(1, 0, 32'h20, 4'hF, 0, 1);
    check("stl_gnt1", 32'(obi_gnt_o), 1);
    check_rsp("stl_c1", 0, 32'h0, 0);
    cyc(1, 0, 32'h14, 4'hF, 0, 1);
    check("stl_gnt2", 32'(obi_gnt_o), 0);
    check("stl_mem_req2", 32'(mem_req_o), 0);
    check_rsp("stl_c2", 0, 32'h0, 0);
    cyc(1, 0, 32'h14, 4'hF, 0, 1);
    check("stl_gnt_hold", 32'(obi_gnt_o), 0);
    check_rsp("stl_hold", 0, 32'h0, 0);
    cyc(1, 0, 32'h14, 4'hF, 0, 0);
    check("stl_gnt3", 32'(obi_gnt_o), 0);
    check_rsp("stl_rsp0", 1, 32'hDEAD_BEEF, 0);
    cyc(1, 0, 32'h14, 4'hF, 0, 0);
    check("stl_gnt4", 32'(obi_gnt_o), 1);
    check_rsp("stl_rsp1", 1, 32'hAAAA_5678, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("stl_rsp2", 1, 32'h5566_7788, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("stl_idle", 0, 32'h0, 0);

    // Interleaved ok / error / ok
    cyc(1, 0, 32'h10, 4'hF, 0, 0);
    check("mix_gnt0", 32'(obi_gnt_o), 1);
    cyc(1, 0, 32'h0000_8000, 4'hF, 0, 0);
    check("mix_gnt1", 32'(obi_gnt_o), 1);
    check_rsp("mix_rsp0", 1, 32'hDEAD_BEEF, 0);
    cyc(1, 0, 32'h14, 4'hF, 0, 0);
    check("mix_gnt2", 32'(obi_gnt_o), 1);
    check_rsp("mix_rsp1", 1, 32'h0, 1);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("mix_rsp2", 1, 32'h5566_7788, 0);

    // Reset with two transactions in flight
    cyc(1, 0, 32'h10, 4'hF, 0, 1);
    cyc(1, 0, 32'h14, 4'hF, 0, 1);
    cyc(0, 0, 32'h0, 4'hF, 0, 1);
    check_rsp("rst_pre", 0, 32'h0, 0);
    rst_n = 1'b0;
    #1;
    check_rsp("rst_async", 0, 32'h0, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("rst_held", 0, 32'h0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 32'h0, 4'hF, 0, 0);
      check_rsp("rst_no_stale", 0, 32'h0, 0);
    end
    cyc(1, 0, 32'h10, 4'hF, 0, 0);
    check("rst_gnt", 32'(obi_gnt_o), 1);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("rst_new", 1, 32'hDEAD_BEEF, 0);
    cyc(0, 0, 32'h0, 4'hF, 0, 0);
    check_rsp("rst_end", 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
